// File: rtl/conv_output_writer_if.sv
// Output-memory write port of conv_output_writer.
// master drives mem_wr/mem_addr/mem_data, slave returns mem_ready.
interface conv_output_writer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    modport master (
        output mem_wr,
        output mem_addr,
        output mem_data,
        input  mem_ready
    );

    modport slave (
        input  mem_wr,
        input  mem_addr,
        input  mem_data,
        output mem_ready
    );
endinterface

// File: rtl/conv_output_writer.sv
// Buffers convolution output words in a circular FIFO and drains them to
// output memory at sequential addresses from BASE_ADDR.
// Ports: clk, rst (sync, active high); start/wr/wdata/done_in from the
// controller; full/empty/count occupancy; busy, flush_done, overflow
// status; mem = memory write port (mem_wr/addr/data out, mem_ready in).
module conv_output_writer #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   wr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   done_in,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   flush_done,
    output logic                   overflow,
    conv_output_writer_if.master   mem
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_overflow;

    logic w_full;
    logic w_empty;
    logic w_start;
    logic w_push;
    logic w_pop;
    logic w_mem_wr;
    logic w_drop;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_start  = (r_state == S_IDLE) && start;
    assign w_push   = (r_state == S_RUN) && wr && !w_full;
    // A write at full is dropped even if a pop frees a slot this cycle.
    assign w_drop   = (r_state == S_RUN) && wr && w_full;
    assign w_mem_wr = ((r_state == S_RUN) || (r_state == S_DRAIN)) && !w_empty;
    assign w_pop    = w_mem_wr && mem.mem_ready;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start)   w_state_nxt = S_RUN;
            S_RUN:   if (done_in) w_state_nxt = S_DRAIN;
            // count==0 implies mem_wr is low, so nothing is in flight.
            S_DRAIN: if (w_empty) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_addr     <= ADDR_W'(BASE_ADDR);
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_addr <= r_addr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage has no reset; contents are only read when count > 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = r_count;
    assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign flush_done   = (r_state == S_DONE);
    assign overflow     = r_overflow;
    assign mem.mem_wr   = w_mem_wr;
    assign mem.mem_addr = r_addr;
    assign mem.mem_data = r_mem[r_rptr];
endmodule

// File: tb/tb_conv_output_writer.sv
// Self-checking bench for conv_output_writer: queue-based reference model
// compared every cycle, directed scenarios plus randomized traffic.
module tb_conv_output_writer;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 10;
    localparam int BASE   = 'h100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              wr = 1'b0;
    logic [DATA_W-1:0] wdata = '0;
    logic              done_in = 1'b0;
    logic              full;
    logic              empty;
    logic [3:0]        count;
    logic              busy;
    logic              flush_done;
    logic              overflow;

    always #5 clk = ~clk;

    conv_output_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();

    conv_output_writer #(
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .wr(wr),
        .wdata(wdata),
        .done_in(done_in),
        .full(full),
        .empty(empty),
        .count(count),
        .busy(busy),
        .flush_done(flush_done),
        .overflow(overflow),
        .mem(mif)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 60)
                $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle 1=run 2=drain 3=done.
    int          m_phase = 0;
    logic [15:0] m_q[$];
    int          m_addr = BASE;
    bit          m_ovf = 0;
    bit          m_valid = 0;
    int          m_sz;
    bit          m_do_pop;
    bit          m_do_push;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_phase = 0;
            m_q.delete();
            m_addr = BASE;
            m_ovf = 0;
            m_valid = 1;
        end else if (m_valid) begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_q.delete();
                    m_addr = BASE;
                    m_ovf = 0;
                end
                1, 2: begin
                    m_sz = m_q.size();
                    m_do_pop = (m_sz > 0) && mif.mem_ready;
                    m_do_push = (m_phase == 1) && wr && (m_sz < DEPTH);
                    if (m_phase == 1 && wr && m_sz == DEPTH) m_ovf = 1;
                    if (m_do_pop) begin
                        void'(m_q.pop_front());
                        m_addr = (m_addr + 1) % (1 << ADDR_W);
                    end
                    if (m_do_push) m_q.push_back(wdata);
                    if (m_phase == 1 && done_in) m_phase = 2;
                    else if (m_phase == 2 && m_sz == 0) m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    end

    typedef struct {
        int addr;
        int data;
        int cyc;
    } rec_t;

    rec_t log_q[$];
    int   n_flush = 0;
    int   max_count = 0;

    // Compare process: mid-cycle, outputs and inputs settled.
    always @(negedge clk) begin
        if (m_valid) begin
            check("count", count, m_q.size());
            check("full", full, m_q.size() == DEPTH);
            check("empty", empty, m_q.size() == 0);
            check("mem_wr", mif.mem_wr,
                  (m_phase == 1 || m_phase == 2) && m_q.size() > 0);
            check("busy", busy, m_phase == 1 || m_phase == 2);
            check("flush_done", flush_done, m_phase == 3);
            check("overflow", overflow, m_ovf);
            if (mif.mem_wr && m_q.size() > 0) begin
                check("mem_addr", mif.mem_addr, m_addr);
                check("mem_data", mif.mem_data, m_q[0]);
            end
        end
        if (flush_done) n_flush++;
        if (int'(count) > max_count) max_count = int'(count);
        if (mif.mem_wr && mif.mem_ready && !rst)
            log_q.push_back('{int'(mif.mem_addr), int'(mif.mem_data), cyc});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        log_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] d);
        wr = 1'b1;
        wdata = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic finish_layer(input string tag);
        int k;
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        k = 0;
        while ((busy || flush_done) && k < 200) begin
            tick();
            k++;
        end
        check({tag, "_idle_timeout"}, busy || flush_done, 0);
    endtask

    logic [15:0] d[20];
    int          push_cyc[5];
    int          nf;

    initial begin
        mif.mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_mem_wr", mif.mem_wr, 0);

        // Basic stream
        nf = n_flush;
        do_start();
        mif.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_word(16'h0011 + 16'(i));
            push_cyc[i] = cyc;
        end
        finish_layer("basic");
        check("basic_len", log_q.size(), 5);
        if (log_q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("basic_addr", log_q[i].addr, 'h100 + i);
                check("basic_data", log_q[i].data, 'h11 + i);
                check("basic_lat", log_q[i].cyc, push_cyc[i]);
            end
        end
        check("basic_flush", n_flush - nf, 1);

        // Backpressure
        do_start();
        mif.mem_ready = 1'b0;
        push_word(16'h00A1);
        push_word(16'h00A2);
        push_word(16'h00A3);
        for (int i = 0; i < 6; i++) begin
            check("bp_wr", mif.mem_wr, 1);
            check("bp_addr", mif.mem_addr, 'h100);
            check("bp_data", mif.mem_data, 'hA1);
            tick();
        end
        mif.mem_ready = 1'b1;
        finish_layer("bp");
        check("bp_len", log_q.size(), 3);
        if (log_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("bp_addr_seq", log_q[i].addr, 'h100 + i);
                check("bp_data_seq", log_q[i].data, 'hA1 + i);
            end
            check("bp_consec1", log_q[1].cyc, log_q[0].cyc + 1);
            check("bp_consec2", log_q[2].cyc, log_q[1].cyc + 1);
        end

        // Full / overflow
        do_start();
        mif.mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            d[i] = 16'($urandom);
            push_word(d[i]);
            if (i == 7) begin
                check("ovf_full", full, 1);
                check("ovf_count8", count, 8);
                check("ovf_pre", overflow, 0);
            end
        end
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 8);
        mif.mem_ready = 1'b1;
        finish_layer("ovf");
        check("ovf_len", log_q.size(), 8);
        if (log_q.size() == 8)
            for (int i = 0; i < 8; i++)
                check("ovf_data", log_q[i].data, d[i]);

        // Pointer wrap
        max_count = 0;
        do_start();
        mif.mem_ready = 1'b1;
        wr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d[i] = 16'($urandom);
            wdata = d[i];
            tick();
        end
        wr = 1'b0;
        finish_layer("wrap");
        check("wrap_len", log_q.size(), 20);
        if (log_q.size() == 20)
            for (int i = 0; i < 20; i++) begin
                check("wrap_data", log_q[i].data, d[i]);
                check("wrap_addr", log_q[i].addr, 'h100 + i);
            end
        check("wrap_maxcount", max_count <= 2, 1);

        // Simultaneous push/pop at full
        do_start();
        mif.mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d[i] = 16'($urandom);
            push_word(d[i]);
        end
        check("sim_count8", count, 8);
        wr = 1'b1;
        wdata = 16'hBEEF;
        mif.mem_ready = 1'b1;
        tick();
        wr = 1'b0;
        check("sim_ovf", overflow, 1);
        check("sim_count7", count, 7);
        finish_layer("sim");
        check("sim_len", log_q.size(), 8);
        if (log_q.size() == 8)
            for (int i = 0; i < 8; i++)
                check("sim_data", log_q[i].data, d[i]);

        // Reset mid-drain
        do_start();
        mif.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(16'h0C00 + 16'(i));
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        check("rd_busy", busy, 1);
        nf = n_flush;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rd_mem_wr", mif.mem_wr, 0);
        check("rd_count", count, 0);
        check("rd_busy0", busy, 0);
        check("rd_flush", flush_done, 0);
        repeat (3) tick();
        check("rd_noflush", n_flush, nf);
        do_start();
        mif.mem_ready = 1'b1;
        push_word(16'h0D01);
        push_word(16'h0D02);
        finish_layer("rd");
        check("rd_len", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("rd_base", log_q[0].addr, 'h100);
            check("rd_data", log_q[1].data, 'h0D02);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 20) == 0;
            wr = $urandom % 2;
            wdata = 16'($urandom);
            mif.mem_ready = ($urandom % 3) != 0;
            done_in = ($urandom % 40) == 0;
            rst = ($urandom % 500) == 0;
            tick();
        end
        start = 1'b0;
        wr = 1'b0;
        done_in = 1'b0;
        rst = 1'b0;
        mif.mem_ready = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
